// File: rtl/fb_dyn_branch_pred_pkg.sv
// Shared opcodes, BHT counter encodings, jalr lock states and immediate decode
// for the dynamic branch predictor.
package fb_dyn_branch_pred_pkg;

  localparam logic [6:0] FB_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] FB_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] FB_OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] FB_BHT_SNT = 2'b00;
  localparam logic [1:0] FB_BHT_WNT = 2'b01;
  localparam logic [1:0] FB_BHT_WT  = 2'b10;
  localparam logic [1:0] FB_BHT_ST  = 2'b11;

  typedef enum logic {
    FB_JL_IDLE = 1'b0,
    FB_JL_WAIT = 1'b1
  } fb_jl_state_e;

  // Sign-extended immediate for the control-transfer formats; zero for anything else.
  function automatic logic [31:0] fb_imm_gen(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      FB_OPC_JAL:    imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      FB_OPC_JALR:   imm = {{20{inst[31]}}, inst[31:20]};
      FB_OPC_BRANCH: imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      default:       imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/fb_bht.sv
// Branch history table: array of 2-bit saturating counters, one combinational
// read port and one clocked saturating update port.
module fb_bht
  import fb_dyn_branch_pred_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 64,
  parameter logic [1:0]  BHT_INIT  = FB_BHT_WNT,
  localparam int unsigned IdxW     = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IdxW-1:0] rd_idx,
  output logic [1:0]      rd_ctr,
  input  logic            upd_en,
  input  logic [IdxW-1:0] upd_idx,
  input  logic            upd_taken
);

  logic [1:0] ctr_q [BHT_DEPTH];
  logic [1:0] upd_cur;
  logic [1:0] upd_nxt;

  // Read is the pre-update value; no write-to-read bypass.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    upd_cur = ctr_q[upd_idx];
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != FB_BHT_ST) upd_nxt = upd_cur + 2'd1;
    end else begin
      if (upd_cur != FB_BHT_SNT) upd_nxt = upd_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        ctr_q[i] <= BHT_INIT;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= upd_nxt;
    end
  end

endmodule

// File: rtl/fb_dyn_branch_pred.sv
// IF-stage dynamic branch predictor with jalr one-cycle lock and EX-stage redirect.
// Optional statistics counters are enabled by defining FB_BPRED_STATS_EN.
module fb_dyn_branch_pred
  import fb_dyn_branch_pred_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter logic [1:0]  BHT_INIT  = FB_BHT_WNT,
  localparam int unsigned BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] predict_pc,
  output logic            pc_src,
  output logic            lock,
  output logic            address_src,
  output logic [XLEN-1:0] redirect_pc,
  output logic            register_rst
`ifdef FB_BPRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  logic            is_jal;
  logic            is_jalr;
  logic            is_btype;
  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] jalr_tgt;
  logic [1:0]      bht_ctr;
  logic            mispredict;

  fb_jl_state_e state_q, state_d;

  assign is_jal   = (inst[6:0] == FB_OPC_JAL);
  assign is_jalr  = (inst[6:0] == FB_OPC_JALR);
  assign is_btype = (inst[6:0] == FB_OPC_BRANCH);

  assign imm_x    = XLEN'($signed(fb_imm_gen(inst)));
  assign pc_seq   = pc + XLEN'(1);
  assign pc_imm   = pc + imm_x;
  assign jalr_tgt = (rs1_data + imm_x) & ~XLEN'(1);

  fb_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .BHT_INIT  (BHT_INIT)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc[BHT_IDX_W-1:0]),
    .rd_ctr    (bht_ctr),
    .upd_en    (ex_valid),
    .upd_idx   (ex_pc[BHT_IDX_W-1:0]),
    .upd_taken (ex_taken)
  );

  assign pred_taken = is_btype & if_valid & bht_ctr[1];

  always_comb begin
    predict_pc = pc_seq;
    if (is_jal) begin
      predict_pc = pc_imm;
    end else if (is_jalr) begin
      predict_pc = jalr_tgt;
    end else if (is_btype) begin
      predict_pc = pred_taken ? pc_imm : pc_seq;
    end
  end

  assign pc_src = if_valid & (is_jal | is_btype | (is_jalr & (state_q == FB_JL_WAIT)));

  assign mispredict   = ex_valid & (ex_taken ^ ex_pred_taken);
  assign address_src  = mispredict;
  assign register_rst = mispredict;
  assign redirect_pc  = ex_taken ? ex_target : ex_pc + XLEN'(1);

  // A flush always wins over the jalr stall and drops any pending lock.
  always_comb begin
    state_d = state_q;
    lock    = 1'b0;
    case (state_q)
      FB_JL_IDLE: begin
        if (if_valid & is_jalr & ~mispredict) begin
          lock    = ~rst;
          state_d = FB_JL_WAIT;
        end
      end
      FB_JL_WAIT: state_d = FB_JL_IDLE;
      default:    state_d = FB_JL_IDLE;
    endcase
    if (mispredict) state_d = FB_JL_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FB_JL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef FB_BPRED_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispred_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (ex_valid)   stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict) stat_mispred_q  <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule
